// File: rtl/note_tone_gen_if.sv
// Note/tone bus between the key encoder side and the tone generator.
// The master drives the note request; the slave returns the audio output and status.
interface note_tone_gen_if;
  logic [2:0] note_idx;
  logic       note_valid;
  logic       tone_out;
  logic       active;
  logic [2:0] cur_note;

  modport master (
    output note_idx,
    output note_valid,
    input  tone_out,
    input  active,
    input  cur_note
  );

  modport slave (
    input  note_idx,
    input  note_valid,
    output tone_out,
    output active,
    output cur_note
  );
endinterface

// File: rtl/note_tone_gen.sv
// Glitch-free diatonic square-wave tone generator (C4..C5) driven by an encoded key index.
// Optional key-release sustain is compiled in with the TONE_SUSTAIN_EN macro.
module note_tone_gen #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned SUSTAIN_CYC = 5_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  note_tone_gen_if.slave nt
);

`ifdef TONE_SUSTAIN_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam int unsigned SUS_W = (SUSTAIN_CYC > 1) ? $clog2(SUSTAIN_CYC) : 1;
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSTAIN_CYC - 1);

  logic [SUS_W-1:0] sus_q, sus_d;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_RELEASE = 2'd3
  } state_e;

  logic unused_sustain_c;
  assign unused_sustain_c = |SUSTAIN_CYC;
`endif

  localparam int unsigned FREQ [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cur_note_q, cur_note_d;
  logic             tone_q, tone_d;
  logic             active_q, active_d;

  // Terminal counts (HALF-1) per note, all constants folded at elaboration.
  logic [CNT_W-1:0] half_m1 [8];
  for (genvar g = 0; g < 8; g++) begin : g_half
    assign half_m1[g] = CNT_W'(CLK_HZ / (2 * FREQ[g]) - 1);
  end

  logic             term_c;
  logic             change_c;
  logic [CNT_W-1:0] step_cnt_c;
  logic             step_tone_c;

  assign term_c      = (cnt_q == half_m1[cur_note_q]);
  assign change_c    = nt.note_valid && (nt.note_idx != cur_note_q);
  assign step_cnt_c  = term_c ? '0 : cnt_q + CNT_W'(1);
  assign step_tone_c = term_c ? ~tone_q : tone_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_note_d = cur_note_q;
    tone_d     = tone_q;
`ifdef TONE_SUSTAIN_EN
    sus_d      = sus_q;
`endif
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        cnt_d  = '0;
        if (nt.note_valid) begin
          state_d    = S_PLAY;
          cur_note_d = nt.note_idx;
          tone_d     = 1'b1;
        end
      end
      S_PLAY: begin
        // A note change restarts the half period and holds the current level.
        if (change_c) begin
          cur_note_d = nt.note_idx;
          cnt_d      = '0;
        end else begin
          cnt_d  = step_cnt_c;
          tone_d = step_tone_c;
          if (!nt.note_valid) begin
`ifdef TONE_SUSTAIN_EN
            state_d = S_SUSTAIN;
            sus_d   = '0;
`else
            state_d = S_RELEASE;
`endif
          end
        end
      end
`ifdef TONE_SUSTAIN_EN
      S_SUSTAIN: begin
        if (change_c) begin
          state_d    = S_PLAY;
          cur_note_d = nt.note_idx;
          cnt_d      = '0;
        end else begin
          cnt_d  = step_cnt_c;
          tone_d = step_tone_c;
          if (nt.note_valid) begin
            state_d = S_PLAY;
          end else if (sus_q == SUS_LAST) begin
            state_d = S_RELEASE;
          end else begin
            sus_d = sus_q + SUS_W'(1);
          end
        end
      end
`endif
      S_RELEASE: begin
        // Finish the current high half before going silent.
        if (change_c) begin
          state_d    = S_PLAY;
          cur_note_d = nt.note_idx;
          cnt_d      = '0;
        end else if (nt.note_valid) begin
          state_d = S_PLAY;
          cnt_d   = step_cnt_c;
          tone_d  = step_tone_c;
        end else if (!tone_q || term_c) begin
          state_d = S_IDLE;
          tone_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_note_q <= '0;
      tone_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_note_q <= cur_note_d;
      tone_q     <= tone_d;
      active_q   <= active_d;
    end
  end

`ifdef TONE_SUSTAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sus_q <= '0;
    end else begin
      sus_q <= sus_d;
    end
  end
`endif

  assign nt.tone_out = tone_q;
  assign nt.active   = active_q;
  assign nt.cur_note = cur_note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen: a time-arithmetic tone model predicts every cycle's outputs.
// Honours TONE_SUSTAIN_EN so the same bench covers both builds.
module tb_note_tone_gen;
  localparam int unsigned CLK_HZ = 52_800;
  localparam int unsigned SUS_CYC = 300;
`ifdef TONE_SUSTAIN_EN
  localparam int SUS = SUS_CYC;
`else
  localparam int SUS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  note_tone_gen_if bus ();

  note_tone_gen #(
    .CLK_HZ      (CLK_HZ),
    .CNT_W       (17),
    .SUSTAIN_CYC (SUS_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nt    (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int freq [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

  logic [4:0] exp_q [$];
  int         rise_q [$];
  int         cyc = 0;
  logic       prev_tone = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the tone is a pure function of time since the last restart point.
  int m_t = 0, m_note = 0, m_anchor = 0, m_lvl = 0, m_reledge = 0;
  bit m_snd = 0, m_rel = 0;

  function automatic int half(input int n);
    return int'(CLK_HZ) / (2 * freq[n]);
  endfunction

  function automatic int lvl_at(input int t);
    return m_lvl ^ (((t - m_anchor) / half(m_note)) & 1);
  endfunction

  task automatic model_reset();
    m_snd = 0; m_rel = 0; m_note = 0;
  endtask

  task automatic model_step(input bit v, input int idx);
    int t;
    m_t++;
    t = m_t;
    if (!m_snd) begin
      if (v) begin
        m_snd = 1; m_rel = 0; m_note = idx; m_anchor = t; m_lvl = 1;
      end
    end else if (v) begin
      m_rel = 0;
      if (idx != m_note) begin
        m_lvl = lvl_at(t - 1); m_note = idx; m_anchor = t;
      end
    end else if (!m_rel) begin
      m_rel = 1; m_reledge = t;
    end else if (t > m_reledge + SUS && (lvl_at(t - 1) == 0 || lvl_at(t) == 0)) begin
      m_snd = 0;
    end
    exp_q.push_back({(m_snd ? 1'(lvl_at(t)) : 1'b0), 1'(m_snd), 3'(m_note)});
  endtask

  task automatic drive(input bit v, input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.note_valid = v;
      bus.note_idx   = v ? 3'(idx) : 3'($urandom);
      model_step(v, idx);
    end
  endtask

  // Monitor: one expected tuple per clock edge while stimulus is running.
  always @(posedge clk) begin
    logic [4:0] e;
    #1;
    cyc++;
    if (bus.tone_out && !prev_tone) rise_q.push_back(cyc);
    prev_tone = bus.tone_out;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("cycle%0d {tone,active,cur}", cyc),
            int'({bus.tone_out, bus.active, bus.cur_note}), int'(e));
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.note_valid = 1'b0;
    bus.note_idx   = 3'd0;

    // Reset held: inputs wiggle, outputs must stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset hold", int'({bus.tone_out, bus.active, bus.cur_note}), 0);
      bus.note_valid = 1'($urandom);
      bus.note_idx   = 3'($urandom);
    end
    @(negedge clk);
    bus.note_valid = 1'b0;
    rst_n          = 1'b1;
    model_reset();
    drive(0, 0, 5);

    // A4 steady tone, period measured from rising edges.
    rise_q.delete();
    drive(1, 5, 300);
    check("a4 rise count", int'(rise_q.size() >= 3), 1);
    if (rise_q.size() >= 3) begin
      check("a4 period 1", rise_q[1] - rise_q[0], 120);
      check("a4 period 2", rise_q[2] - rise_q[1], 120);
    end
    drive(0, 0, SUS + 150);

    // C4 then switch to C5 mid-note.
    drive(1, 0, 130);
    drive(1, 7, 250);
    drive(0, 0, SUS + 120);

    // C4 released 10 cycles into a high half, then released during a low half.
    drive(1, 0, 210);
    drive(0, 0, SUS + 150);
    drive(1, 0, 150);
    drive(0, 0, SUS + 120);

    // A4 released in a high half, re-pressed on D4 20 cycles later.
    drive(1, 5, 130);
    drive(0, 0, 20);
    drive(1, 1, 100);
    drive(0, 0, SUS + 200);

    // Asynchronous reset mid-note (mid-sustain in the sustain build).
    drive(1, 2, 70);
    drive(0, 0, 40);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset", int'({bus.tone_out, bus.active, bus.cur_note}), 0);
    @(negedge clk);
    check("reset held", int'({bus.tone_out, bus.active, bus.cur_note}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(0, 0, 4);

    // Randomised key activity.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0, 1: drive(1, int'($urandom_range(0, 7)), int'($urandom_range(5, 250)));
        2:    drive(0, 0, int'($urandom_range(1, 250)));
        default: drive(1, int'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
      endcase
    end
    drive(0, 0, SUS + 250);

    @(posedge clk);
    #3;
    check("scoreboard drained", exp_q.size(), 0);
    check("idle at end", int'({bus.tone_out, bus.active}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Square-wave tone generator directly downstream of the 8-to-3 key encoder. It takes the 3-bit note index plus a key-held flag and produces a 1-bit audio square wave at the matching pitch, from C4 to C5 in the diatonic scale. Note starts, stops and changes are glitch-free. Its output drives the buzzer/audio pin.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; sets the divider table.
- `CNT_W`, default 17: half-period counter width; must hold the largest `HALF[i]-1`.
- `SUSTAIN_CYC`, default 5_000_000: sustain length in cycles. Used only with `TONE_SUSTAIN_EN`.
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `note_idx`, in, 3: note index from the encoder. 0=C4, 1=D4, …, 7=C5.
- `note_valid`, in, 1: key held (OR of the one-hot key bus); `note_idx` is meaningful only while this is 1.
- `tone_out`, out, 1: square-wave audio output.
- `active`, out, 1: high whenever state ≠ IDLE.
- `cur_note`, out, 3: latched note currently sounding.

## Operation
- Frequency table F[0..7] in Hz: 262, 294, 330, 349, 392, 440, 494, 523.
- `HALF[i] = CLK_HZ / (2*F[i])`, using integer truncation, evaluated at elaboration.
  - At 50 MHz: 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- Registers: `state`, `cnt` (`CNT_W` bits), `cur_note`, `tone_out`.
- Reset values: state=IDLE, cnt=0, cur_note=0, tone_out=0, active=0.
- Reset asserted mid-note forces all of the above immediately, without waiting for a clock edge.
- IDLE:
  - tone_out=0, cnt=0.
  - On `note_valid`=1: go to PLAY; cur_note←note_idx; tone_out←1; cnt←0.
- PLAY:
  - cnt increments each cycle.
  - When cnt==HALF[cur_note]−1: toggle tone_out and set cnt←0.
  - Note change (`note_valid`=1, note_idx≠cur_note): cur_note←note_idx; cnt←0; tone_out holds its level (no toggle that cycle).
  - Note change and a terminal count in the same cycle: the note change wins.
  - On `note_valid`=0: go to SUSTAIN with the macro, otherwise to RELEASE. cnt keeps counting.
- SUSTAIN (macro only):
  - Tone continues exactly as in PLAY.
  - A sustain counter runs for `SUSTAIN_CYC` cycles, then the state goes to RELEASE.
  - `note_valid`=1 during SUSTAIN: return to PLAY and apply the note-change rule if the index differs.
- RELEASE:
  - If tone_out=0: go to IDLE on the next edge.
  - Otherwise keep counting. At the terminal count, tone_out←0 and state←IDLE on the same edge, so the last high half-period is never truncated.
  - `note_valid`=1 during RELEASE: go to PLAY with the note-change rule. tone_out is not forced high.
- `cnt` never exceeds HALF−1; on wrap it returns to 0.

## Timing
- Start latency: `note_valid` sampled high at edge k → tone_out=1 and active=1 after edge k.
- Periodicity: tone_out toggles at edges k+HALF, k+2·HALF, …, giving period 2·HALF cycles and 50% duty.
- Note change sampled at edge m:
  - cur_note updates after edge m.
  - The next toggle comes at edge m+HALF[new].
- Release without macro:
  - `note_valid` low sampled at edge r.
  - tone_out falls at the first terminal count after r, or stays low if already low.
  - active falls with it.
- Release with macro: add `SUSTAIN_CYC` cycles before RELEASE is entered.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `TONE_SUSTAIN_EN` defined:
  - SUSTAIN state and its sustain counter are compiled in.
  - The tone persists `SUSTAIN_CYC` cycles after key release, then ends cleanly.
- `TONE_SUSTAIN_EN` undefined:
  - No SUSTAIN state and no sustain counter.
  - PLAY goes straight to RELEASE; `SUSTAIN_CYC` is ignored.

## Test plan
The bench uses CLK_HZ=52_800, which gives HALF values of 100 for C4, 60 for A4 and 50 for C5.
- Reset: hold rst_n=0, apply clocks and toggle inputs → tone_out=0, active=0, cur_note=0 throughout. Release reset → still IDLE.
- A4 steady tone: note_idx=5, note_valid=1 at edge k → tone_out=1 after k, toggles every 60 cycles, measured period 120. cur_note=5.
- Note change: C4 playing, switch to C5 at edge m → level held, next toggle at m+50, then a period of 100.
- Clean stop, no macro: drop note_valid 10 cycles into a high half of C4 → tone_out stays high 90 more cycles, then 0 and active=0 on the same edge. Dropping during a low half → active=0 the next cycle.
- Re-press during RELEASE: A4 released in a high half, pressed again on D4 20 cycles later → back to PLAY, cur_note=1, no extra edge on tone_out.
- Sustain (macro on, SUSTAIN_CYC=300): release A4 → tone continues ≥300 cycles, then ends at the next falling edge. Reset asserted mid-sustain → all outputs 0 immediately.
